// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display with a double-buffered display word.
// Optional build macro: LZ_BLANK_EN enables leading-zero suppression.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt, cnt_nxt;
  logic [IW-1:0]             idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0]   active, pending;
  logic [NUM_DIGITS-1:0]     active_dp, pending_dp;
  logic [NUM_DIGITS-1:0]     lzm;
  logic [NUM_DIGITS-1:0]     an_sel;
  logic [3:0]                cur_nib;
  logic                      cur_dp, cur_lz;
  logic                      tick, boundary, dark;

  // Shared hex decoder, active-low segments in gfedcba order.
  function automatic logic [6:0] hex_2_7seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef LZ_BLANK_EN
  // Bit k set when digit k (k>0) and every more significant nibble is zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] w);
    logic [NUM_DIGITS-1:0] m;
    logic                  z;
    m = '0;
    z = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      z    = z & (w[4*k +: 4] == 4'h0);
      m[k] = z;
    end
    return m;
  endfunction

  assign lzm = lz_mask(active);
`else
  assign lzm = '0;
`endif

  assign tick     = (cnt == CNT_LAST);
  assign boundary = en && tick && (idx == IDX_LAST);
  assign dark     = !en || (cnt < CNT_BLANK);

  // Next scan position: prescaler and digit index only move while enabled.
  always_comb begin
    cnt_nxt = cnt;
    idx_nxt = idx;
    if (en) begin
      if (tick) begin
        cnt_nxt = '0;
        idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Select the nibble, decimal point and anode of the digit being scanned.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    an_sel  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = active[4*k +: 4];
        cur_dp    = active_dp[k];
        cur_lz    = lzm[k];
        an_sel[k] = 1'b0;
      end
    end
  end

  // Scan state, double buffer and registered pin drive.
  // frame_done is raised while the state sits on the last cycle of the frame,
  // so a load presented in that same cycle lands on the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      active_dp  <= '0;
      pending    <= '0;
      pending_dp <= '0;
      busy       <= 1'b0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      frame_done <= en && (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);

      if (boundary) begin
        if (load) begin
          active    <= data_in;
          active_dp <= dp_in;
        end else if (busy) begin
          active    <= pending;
          active_dp <= pending_dp;
        end
        busy <= 1'b0;
      end else if (load) begin
        pending    <= data_in;
        pending_dp <= dp_in;
        busy       <= 1'b1;
      end

      if (dark) begin
        seg <= 7'h7F;
        dp  <= 1'b1;
        an  <= '1;
      end else begin
        seg <= cur_lz ? 7'h7F : hex_2_7seg(cur_nib);
        dp  <= ~cur_dp;
        an  <= an_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scenarios plus randomized traffic for
// seg7_scan_ctrl, checked cycle by cycle against a frame-position model.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        busy;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: position within the frame and the two buffers.
  int          m_pos;
  logic [15:0] m_word, m_pend_word;
  logic [3:0]  m_dpv, m_pend_dp;
  logic        m_busy;
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_an = 4'hF;
  logic        exp_dp = 1'b1;
  logic        exp_busy = 1'b0;
  logic        exp_fd = 1'b0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check_eq("seg", {25'd0, seg}, {25'd0, exp_seg});
    check_eq("an", {28'd0, an}, {28'd0, exp_an});
    check_eq("dp", {31'd0, dp}, {31'd0, exp_dp});
    check_eq("busy", {31'd0, busy}, {31'd0, exp_busy});
    check_eq("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
  endtask

  function automatic logic [3:0] nib_of(input logic [15:0] w, input int d);
    return 4'((w >> (4 * d)) & 16'hF);
  endfunction

  function automatic bit lz_hides(input logic [15:0] w, input int d);
`ifdef LZ_BLANK_EN
    if (d == 0) return 1'b0;
    return (w >> (4 * d)) == 16'h0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pos = 0; m_word = '0; m_dpv = '0; m_pend_word = '0; m_pend_dp = '0; m_busy = 1'b0;
  endtask

  // Expected pins after the coming edge, from the state before it, then advance.
  task automatic model_eval();
    int digit, phase;
    digit = m_pos / DIV;
    phase = m_pos % DIV;
    if (!en || phase < BLK) begin
      exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1;
    end else begin
      exp_an  = ~(4'b0001 << digit);
      exp_seg = lz_hides(m_word, digit) ? 7'h7F : seg_tbl[nib_of(m_word, digit)];
      exp_dp  = ~m_dpv[digit];
    end
    if (en && m_pos == FRAME - 1) begin
      if (load) begin
        m_word = data_in; m_dpv = dp_in;
      end else if (m_busy) begin
        m_word = m_pend_word; m_dpv = m_pend_dp;
      end
      m_busy = 1'b0;
    end else if (load) begin
      m_pend_word = data_in; m_pend_dp = dp_in; m_busy = 1'b1;
    end
    if (en) m_pos = (m_pos + 1) % FRAME;
    exp_busy = m_busy;
    exp_fd   = en && (m_pos == FRAME - 1);
  endtask

  task automatic step(input logic e, input logic l, input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    compare_outputs();
    en = e; load = l; data_in = d; dp_in = p;
    model_eval();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 2 * FRAME && m_pos != target; i++) idle(1);
    check_eq("run_to_reached", m_pos, target);
  endtask

  task automatic check_reset_pins(input string tag);
    check_eq({tag, "_seg"}, {25'd0, seg}, 32'h7F);
    check_eq({tag, "_an"}, {28'd0, an}, 32'hF);
    check_eq({tag, "_dp"}, {31'd0, dp}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
  endtask

  // Assert reset mid-cycle, verify the immediate blank, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    compare_outputs();
    #2 rst = 1'b1;
    #1 check_reset_pins("rst_async");
    @(negedge clk);
    check_reset_pins("rst_hold");
    rst = 1'b0; en = 1'b0; load = 1'b0;
    model_reset();
    model_eval();
  endtask

  int fd_count;

  initial begin
    model_reset();
    do_reset();

    // Load 1234 before the first boundary, watch three frames.
    step(1'b1, 1'b1, 16'h1234, 4'b0000);
    idle(3 * FRAME);

    // Mid-frame load of ABCD, pending until the boundary; count frame pulses.
    run_to(DIV + 4);
    step(1'b1, 1'b1, 16'hABCD, 4'b0010);
    fd_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle(1);
      if (frame_done === 1'b1) fd_count++;
    end
    check_eq("fd_per_2frames", fd_count, 2);

    // Load exactly in the frame_done cycle goes straight to the display.
    run_to(FRAME - 1);
    step(1'b1, 1'b1, 16'h00F0, 4'b0000);
    idle(FRAME + 4);

    // Pause the scan mid-slot, including a load while paused.
    run_to(DIV + 4);
    for (int i = 0; i < 20; i++) step(1'b0, (i == 7), 16'h0050, 4'b0100);
    idle(2 * FRAME);
    step(1'b1, 1'b1, 16'h0000, 4'b0001);
    idle(2 * FRAME);

    // Reset in the lit phase of digit 2 with pending data.
    run_to(1);
    step(1'b1, 1'b1, 16'h9876, 4'b1111);
    run_to(2 * DIV + 4);
    do_reset();
    idle(FRAME + 8);

    // Randomized traffic with boundary-aligned loads and enable gaps.
    for (int i = 0; i < 1500; i++) begin
      logic e, l;
      e = ($urandom_range(0, 9) != 0);
      l = (m_pos == FRAME - 1) ? 1'($urandom) : ($urandom_range(0, 15) == 0);
      step(e, l, ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
           4'($urandom));
    end
    step(1'b1, 1'b0, 16'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
